// File: rtl/gelu_pipe.sv
// gelu_pipe
//   Pipelined fixed-point activation unit for the arithmetic unit. It sits
//   between operand fetch and result writeback. Per sample it evaluates
//   GELU, ReLU or bypass. GELU uses the tanh approximation
//     0.5*x*(1 + tanh(0.79788*(x + 0.044715*x^3)))
//   with tanh replaced by a piecewise-linear hard-tanh.
//   There are three register stages with valid/ready on both sides.
//   Every narrowing step rounds half-to-even.
//
//   Build option GELU_PIPE_CLIP_CNT_EN:
//     defined     - o_clip_cnt counts GELU samples whose tanh argument
//                   clipped (|u| >= 1.5). It saturates at 0xFFFF.
//     not defined - the counter is absent and o_clip_cnt reads 0.
//
// Ports
//   i_clk, i_rst       clock; asynchronous active-high reset
//   i_valid / o_ready  input handshake (o_ready = ~o_valid | i_ready)
//   i_data, i_mode     signed Q(DW-FW).FW sample; 00 GELU, 01 ReLU,
//                      10/11 bypass
//   o_valid / i_ready  output handshake
//   o_data             signed Q(DW-FW).FW result
//   o_clip_cnt         hard-tanh clip event count
module gelu_pipe #(
  parameter int DW = 16,
  parameter int FW = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  input  logic [1:0]    i_mode,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data,
  output logic [15:0]   o_clip_cnt
);

  localparam int K0  = $rtoi(0.7978845608 * $itor(1 << FW) + 0.5);
  localparam int K1  = $rtoi(0.044715 * $itor(1 << FW) + 0.5);
  localparam int KW  = FW + 2;
  localparam int X2W = 2 * DW;
  localparam int PW  = DW + KW;
  localparam int QW  = X2W + KW + 1;
  localparam int VW  = PW + QW;
  localparam int TW  = DW + 1;
  localparam int GW  = DW + FW + 3;
  localparam int SV  = 4 * FW;
  localparam int SG  = FW + 1;

  localparam logic signed [PW-1:0] K0_P   = PW'(K0);
  localparam logic signed [QW-1:0] K1_Q   = QW'(K1);
  localparam logic signed [QW-1:0] ONE_Q3 = QW'(1) << (3 * FW);
  localparam logic signed [DW-1:0] TH_HI  = DW'(3 << (FW - 1));
  localparam logic signed [DW-1:0] TH_HIN = -TH_HI;
  localparam logic signed [DW-1:0] TH_LO  = DW'(1 << (FW - 1));
  localparam logic signed [DW-1:0] TH_LON = -TH_LO;
  localparam logic signed [TW-1:0] T_ONE  = TW'(1 << (FW + 1));
  localparam logic signed [TW-1:0] T_QTR  = TW'(1 << (FW - 1));
  localparam logic signed [GW-1:0] G_ONE  = GW'(1 << FW);
  localparam logic [DW-1:0]        D_MAX  = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]        D_MIN  = {1'b1, {(DW-1){1'b0}}};
  localparam logic [1:0]           MODE_GELU = 2'b00;
  localparam logic [1:0]           MODE_RELU = 2'b01;

  // The whole pipe moves as one; it stalls only when the output register
  // holds a sample that the sink refuses.
  logic en;
  assign en      = ~o_valid | i_ready;
  assign o_ready = en;

  // Stage 1 inputs: x^2 and x*K0, both Q2FW.
  logic signed [X2W-1:0] x_x2w, x2_c;
  logic signed [PW-1:0]  x_pw, p_c;

  assign x_x2w = {{(X2W-DW){i_data[DW-1]}}, i_data};
  assign x_pw  = {{(PW-DW){i_data[DW-1]}}, i_data};
  assign x2_c  = x_x2w * x_x2w;
  assign p_c   = x_pw * K0_P;

  logic                  s1_valid;
  logic signed [DW-1:0]  s1_x;
  logic [1:0]            s1_mode;
  logic signed [X2W-1:0] s1_x2;
  logic signed [PW-1:0]  s1_p;

  // Stage 2 inputs: v = p*(1 + K1*x^2) in Q5FW, reduced to u in QFW.
  logic signed [QW-1:0] x2_q, q_c;
  logic signed [VW-1:0] p_v, q_v, v_c, v_sh, v_r;
  logic                 v_inc, u_ovf;
  logic signed [DW-1:0] u_c;
  logic signed [TW-1:0] u_t, t2_c;
  logic                 t_inc;
  logic signed [DW-1:0] t_c;

  assign x2_q = {{(QW-X2W){s1_x2[X2W-1]}}, s1_x2};
  assign q_c  = ONE_Q3 + x2_q * K1_Q;
  assign p_v  = {{(VW-PW){s1_p[PW-1]}}, s1_p};
  assign q_v  = {{(VW-QW){q_c[QW-1]}}, q_c};
  assign v_c  = p_v * q_v;

  // Round half to even: bump when the dropped part is above half, or when
  // it is exactly half and the kept LSB is odd.
  assign v_inc = v_c[SV-1] & ((|v_c[SV-2:0]) | v_c[SV]);
  assign v_sh  = v_c >>> SV;
  assign v_r   = v_sh + {{(VW-1){1'b0}}, v_inc};
  assign u_ovf = v_r[VW-1:DW-1] != {(VW-DW+1){v_r[VW-1]}};
  assign u_c   = u_ovf ? (v_r[VW-1] ? D_MIN : D_MAX) : v_r[DW-1:0];

  // Hard-tanh in Q(FW+1). At that scale 0.5*u has the same integer value as u.
  assign u_t = {u_c[DW-1], u_c};
  always_comb begin
    t2_c = u_t <<< 1;
    if (u_c >= TH_HI) begin
      t2_c = T_ONE;
    end else if (u_c <= TH_HIN) begin
      t2_c = -T_ONE;
    end else if (u_c > TH_LO) begin
      t2_c = u_t + T_QTR;
    end else if (u_c < TH_LON) begin
      t2_c = u_t - T_QTR;
    end
  end

  assign t_inc = t2_c[0] & t2_c[1];
  assign t_c   = t2_c[DW:1] + {{(DW-1){1'b0}}, t_inc};

  logic                 s2_valid;
  logic signed [DW-1:0] s2_x;
  logic [1:0]           s2_mode;
  logic signed [DW-1:0] s2_t;

  // Stage 3 inputs: y = x*(1 + t), Q2FW, scaled back by 2^(FW+1). The extra
  // bit of shift supplies the 0.5 factor.
  logic signed [GW-1:0] x_g, t_g, opt_g, g_c, g_sh, g_r;
  logic                 g_inc, g_ovf;
  logic [DW-1:0]        y_gelu, y_c;

  assign x_g    = {{(GW-DW){s2_x[DW-1]}}, s2_x};
  assign t_g    = {{(GW-DW){s2_t[DW-1]}}, s2_t};
  assign opt_g  = G_ONE + t_g;
  assign g_c    = x_g * opt_g;
  assign g_inc  = g_c[SG-1] & ((|g_c[SG-2:0]) | g_c[SG]);
  assign g_sh   = g_c >>> SG;
  assign g_r    = g_sh + {{(GW-1){1'b0}}, g_inc};
  assign g_ovf  = g_r[GW-1:DW-1] != {(GW-DW+1){g_r[GW-1]}};
  assign y_gelu = g_ovf ? (g_r[GW-1] ? D_MIN : D_MAX) : g_r[DW-1:0];

  always_comb begin
    y_c = s2_x;
    case (s2_mode)
      MODE_GELU: y_c = y_gelu;
      MODE_RELU: y_c = (!s2_x[DW-1] && (|s2_x)) ? s2_x : '0;
      default:   y_c = s2_x;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_mode  <= '0;
      s1_x2    <= '0;
      s1_p     <= '0;
      s2_valid <= 1'b0;
      s2_x     <= '0;
      s2_mode  <= '0;
      s2_t     <= '0;
      o_valid  <= 1'b0;
      o_data   <= '0;
    end else if (en) begin
      s1_valid <= i_valid;
      s1_x     <= i_data;
      s1_mode  <= i_mode;
      s1_x2    <= x2_c;
      s1_p     <= p_c;
      s2_valid <= s1_valid;
      s2_x     <= s1_x;
      s2_mode  <= s1_mode;
      s2_t     <= t_c;
      o_valid  <= s2_valid;
      o_data   <= y_c;
    end
  end

`ifdef GELU_PIPE_CLIP_CNT_EN
  logic        clip_c, s2_clip;
  logic [15:0] clip_cnt;

  assign clip_c = (s1_mode == MODE_GELU) && ((u_c >= TH_HI) || (u_c <= TH_HIN));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_clip  <= 1'b0;
      clip_cnt <= '0;
    end else if (en) begin
      s2_clip <= clip_c;
      if (s2_valid && s2_clip && (clip_cnt != 16'hFFFF)) begin
        clip_cnt <= clip_cnt + 16'd1;
      end
    end
  end

  assign o_clip_cnt = clip_cnt;
`else
  assign o_clip_cnt = 16'd0;
`endif

endmodule
